// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC command scheduler: command layout, FSM states
// and the entry legality rule.
package nfc_pkg;

   localparam int CMD_W     = 33;
   localparam int RW_BIT    = 32;
   localparam int FA_HI     = 31;
   localparam int FA_LO     = 14;
   localparam int MA_HI     = 13;
   localparam int MA_LO     = 7;
   localparam int LEN_HI    = 6;
   localparam int LEN_LO    = 0;
   localparam int MEM_WORDS = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BUSY,
      ST_HALT
   } state_t;

   // Legal when the transfer is non-empty and stays inside the 128-word memory.
   function automatic logic cmd_legal(input logic [6:0] ma, input logic [6:0] len);
      logic [7:0] sum;
      sum = {1'b0, ma} + {1'b0, len};
      return (len != 7'd0) && (sum <= 8'(MEM_WORDS));
   endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// DEPTH x CMD_W synchronous command FIFO; full/empty come from the occupancy
// count so that equal pointers are never ambiguous.
module nfc_cmd_fifo
   import nfc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [CMD_W-1:0]           wdata,
   input  logic                       pop,
   output logic [CMD_W-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/nfc_cmd_sched.sv
// Buffers host commands, issues them one at a time on the NFC cmd/done
// handshake and reports each completion; malformed commands are dropped at entry.
module nfc_cmd_sched
   import nfc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ACK_TO = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             h_valid,
   output logic             h_ready,
   input  logic [CMD_W-1:0] h_cmd,
   output logic             h_rej,
   output logic [CMD_W-1:0] cmd,
   input  logic             done,
   output logic             cpl_valid,
   output logic [CMD_W-1:0] cpl_cmd,
   output logic             busy,
   output logic             to_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(ACK_TO + 1);
   localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TO - 1);

   state_t           state;
   logic [TW-1:0]    ack_cnt;
   logic [CMD_W-1:0] head;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             accept;
   logic             legal;
   logic             push;
   logic             pop;

   assign accept  = h_valid && h_ready;
   assign legal   = cmd_legal(h_cmd[MA_HI:MA_LO], h_cmd[LEN_HI:LEN_LO]);
   assign push    = accept && legal;
   assign pop     = (state == ST_IDLE) && done && !empty;
   assign h_ready = !full;
   assign busy    = (count != '0) || (state == ST_ISSUE) || (state == ST_BUSY);

   nfc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (h_cmd),
      .pop   (pop),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         ack_cnt   <= '0;
         cmd       <= '0;
         h_rej     <= 1'b0;
         cpl_valid <= 1'b0;
         cpl_cmd   <= '0;
         to_err    <= 1'b0;
      end else begin
         h_rej     <= accept && !legal;
         cpl_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (done && !empty) begin
                  cmd     <= head;
                  ack_cnt <= '0;
                  state   <= ST_ISSUE;
               end
            end
            // done falling is the NFC's acknowledgement of the new command.
            ST_ISSUE: begin
               if (!done) begin
                  state <= ST_BUSY;
               end else if (ack_cnt == ACK_LAST) begin
                  to_err <= 1'b1;
                  state  <= ST_HALT;
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            ST_BUSY: begin
               if (done) begin
                  cpl_valid <= 1'b1;
                  cpl_cmd   <= cmd;
                  state     <= ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nfc_cmd_sched.sv
// Scoreboard bench for nfc_cmd_sched with a behavioural NFC done/ack model.
module tb_nfc_cmd_sched;

   logic        clk;
   logic        rst;
   logic        h_valid;
   logic        h_ready;
   logic [32:0] h_cmd;
   logic        h_rej;
   logic [32:0] cmd;
   logic        done;
   logic        cpl_valid;
   logic [32:0] cpl_cmd;
   logic        busy;
   logic        to_err;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_cpl[$];
   logic [32:0] exp_issue[$];
   int          exp_rej = 0;

   bit          hold = 0;
   bit          noack = 0;
   int          lat_base = 10;

   nfc_cmd_sched #(.DEPTH(4), .ACK_TO(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .h_valid   (h_valid),
      .h_ready   (h_ready),
      .h_cmd     (h_cmd),
      .h_rej     (h_rej),
      .cmd       (cmd),
      .done      (done),
      .cpl_valid (cpl_valid),
      .cpl_cmd   (cpl_cmd),
      .busy      (busy),
      .to_err    (to_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // NFC model: acks a newly presented cmd one cycle after seeing it, then stays busy.
   logic [32:0] nfc_last;
   int          nfc_t;
   bit          nfc_active;
   always @(negedge clk) begin
      if (!rst) begin
         done = 1'b1; nfc_active = 0; nfc_last = '0; nfc_t = 0;
      end else if (hold) begin
         done = 1'b0;
      end else if (!nfc_active) begin
         done = 1'b1;
         if (cmd != nfc_last) begin
            nfc_last = cmd; nfc_active = 1; nfc_t = 0;
         end
      end else if (!noack) begin
         nfc_t++;
         if (nfc_t == 1) done = 1'b0;
         else if (nfc_t == 1 + lat_base + int'(nfc_last[1:0])) begin
            done = 1'b1; nfc_active = 0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a reject, completion or issue.
   logic [32:0] prev_cmd = '0;
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst && h_rej) begin
         checks++;
         if (exp_rej == 0) begin
            errors++; $display("FAIL h_rej: unexpected pulse, actual=1 required=0");
         end else exp_rej--;
      end
      if (rst && cpl_valid) begin
         checks++;
         if (exp_cpl.size() == 0) begin
            errors++; $display("FAIL cpl_valid: unexpected completion cpl_cmd=%h", cpl_cmd);
         end else begin
            e = exp_cpl.pop_front();
            if (cpl_cmd !== e) begin
               errors++; $display("FAIL cpl_cmd: actual=%h required=%h", cpl_cmd, e);
            end
         end
      end
      if (cmd !== prev_cmd) begin
         if (rst && cmd != '0) begin
            checks++;
            if (exp_issue.size() == 0) begin
               errors++; $display("FAIL issue: unexpected cmd=%h", cmd);
            end else begin
               e = exp_issue.pop_front();
               if (cmd !== e) begin
                  errors++; $display("FAIL issue_order: actual=%h required=%h", cmd, e);
               end
            end
         end
         prev_cmd = cmd;
      end
   end

   function automatic logic [32:0] mk(input logic rw, input logic [17:0] fa,
                                      input logic [6:0] ma, input logic [6:0] len);
      return {rw, fa, ma, len};
   endfunction

   task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++; $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // kind: 0 reject, 1 issue+complete, 2 issue only, 3 accepted but never issued
   task automatic push(input logic [32:0] c, input int kind);
      int unsigned w;
      w = 0;
      @(negedge clk);
      h_valid = 1'b1; h_cmd = c;
      while (!h_ready && w < 200) begin
         @(negedge clk); w++;
      end
      if (w >= 200) begin
         checks++; errors++;
         $display("FAIL push_wait: h_ready actual=0 for %0d cycles, required=1", w);
         h_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      h_valid = 1'b0;
      case (kind)
         0: exp_rej++;
         1: begin exp_issue.push_back(c); exp_cpl.push_back(c); end
         2: exp_issue.push_back(c);
         default: ;
      endcase
   endtask

   task automatic wait_idle(input string nm);
      int unsigned n;
      n = 0;
      while ((exp_cpl.size() != 0 || busy) && n < 2000) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n >= 2000) begin
         errors++; $display("FAIL %s: still busy after %0d cycles, pending=%0d required=0", nm, n, exp_cpl.size());
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; h_valid = 1'b0;
      exp_cpl.delete(); exp_issue.delete(); exp_rej = 0;
      #1;
      chk("rst_cmd", cmd, '0);
      chk("rst_h_ready", h_ready, 1);
      chk("rst_h_rej", h_rej, 0);
      chk("rst_cpl_valid", cpl_valid, 0);
      chk("rst_cpl_cmd", cpl_cmd, '0);
      chk("rst_busy", busy, 0);
      chk("rst_to_err", to_err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [32:0] c;
      rst = 1'b0; h_valid = 1'b0; h_cmd = '0;
      do_reset();
      repeat (2) @(negedge clk);

      // single read, 2-edge push-to-issue latency
      c = mk(1'b1, 18'h00010, 7'h00, 7'd64);
      push(c, 1);
      chk("cmd_before_load", cmd, '0);
      @(posedge clk); #1;
      chk("cmd_latency", cmd, c);
      wait_idle("single_cpl");
      chk("single_busy_fall", busy, 0);

      // fill FIFO while NFC holds done low, then 5th enters after first pop
      lat_base = 3;
      hold = 1;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         push(mk(1'b0, 18'h00100 + 18'(i), 7'(i * 8), 7'(8 + i)), 1);
      @(negedge clk);
      chk("full_h_ready", h_ready, 0);
      chk("full_cmd_held", cmd, c);
      fork
         push(mk(1'b0, 18'h00104, 7'h20, 7'd12), 1);
         begin repeat (3) @(negedge clk); hold = 0; end
      join
      wait_idle("fifo_order");

      // entry legality boundaries
      push(mk(1'b0, 18'h00200, 7'h10, 7'd0), 0);
      push(mk(1'b1, 18'h00201, 7'h7F, 7'd2), 0);
      @(negedge clk);
      chk("rej_no_slot", busy, 0);
      push(mk(1'b1, 18'h00202, 7'h40, 7'd64), 1);
      wait_idle("sum128_accept");

      // acknowledge timeout halts the scheduler
      noack = 1;
      c = mk(1'b1, 18'h00300, 7'h00, 7'd4);
      push(c, 2);
      repeat (16) @(posedge clk);
      #1 chk("to_err_early", to_err, 0);
      @(posedge clk);
      #1 chk("to_err_set", to_err, 1);
      push(mk(1'b0, 18'h00301, 7'h00, 7'd5), 3);
      push(mk(1'b0, 18'h00302, 7'h00, 7'd6), 3);
      repeat (20) @(negedge clk);
      chk("halt_cmd_held", cmd, c);
      chk("halt_busy", busy, 1);
      chk("halt_h_ready", h_ready, 1);

      // reset during BUSY with two queued
      noack = 0;
      lat_base = 8;
      do_reset();
      @(negedge clk);
      push(mk(1'b1, 18'h00400, 7'h00, 7'd4), 2);
      push(mk(1'b0, 18'h00401, 7'h00, 7'd5), 3);
      push(mk(1'b0, 18'h00402, 7'h00, 7'd6), 3);
      repeat (3) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      do_reset();
      repeat (20) @(negedge clk);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_cmd", cmd, '0);

      // alternating write/read stream
      lat_base = 2;
      for (int i = 0; i < 10; i++)
         push(mk(1'(i), 18'h00500 + 18'(i), 7'(i * 4), 7'(4 + i)), 1);
      wait_idle("stream");
      chk("stream_to_err", to_err, 0);

      @(negedge clk);
      chk("left_cpl", 33'(exp_cpl.size()), '0);
      chk("left_issue", 33'(exp_issue.size()), '0);
      chk("left_rej", 33'(exp_rej), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/nfc_cmd_sched.md
# nfc_cmd_sched

Command scheduler that sits directly upstream of the NFC NAND-flash controller. It accepts 33-bit flash/memory transfer commands from a host over a valid/ready port and buffers them in a small FIFO. It issues them one at a time on the NFC `cmd`/`done` handshake and reports each completion back to the host. Malformed commands are rejected at entry so the NFC only ever sees legal transfers.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO entries, power of two, 2..16.
- `ACK_TO`, default 16: cycles `done` may stay high after issue before a timeout is declared.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `h_valid`  in  1  host command valid.
- `h_ready`  out  1  FIFO can accept a command.
- `h_cmd`  in  33  command: [32]=1 read flash→memory, 0 write memory→flash; [31:14] flash address; [13:7] memory address; [6:0] length.
- `h_rej`  out  1  one-cycle pulse: command offered this cycle was dropped as malformed.
- `cmd`  out  33  command to the NFC, registered.
- `done`  in  1  NFC idle/ready; high = previous command finished and next may be presented.
- `cpl_valid`  out  1  one-cycle completion pulse.
- `cpl_cmd`  out  33  the command that just completed, valid with `cpl_valid`.
- `busy`  out  1  FIFO non-empty or a command in flight.
- `to_err`  out  1  sticky timeout flag.

## Operation
- Accept when `h_valid && h_ready`. Reject instead of push, and pulse `h_rej` next cycle, when length==0 or memory address + length > 128 (8-bit sum). Rejected commands consume no slot. `h_ready` still governs: there is no rejection while full.
- `h_ready` = FIFO count < DEPTH, from the registered count. A pop in the same cycle does not open a slot for that cycle.
- FSM states:
  - IDLE: on a clock edge with `done`=1 and FIFO non-empty, load `cmd` ← head, pop, go to ISSUE.
  - ISSUE: wait for `done`=0, which is the NFC acknowledgement, then go to BUSY. If `done` stays 1 for ACK_TO consecutive cycles in ISSUE, set `to_err` and go to HALT.
  - BUSY: on `done`=1, pulse `cpl_valid` with `cpl_cmd` = `cmd`, then go to IDLE.
  - HALT: terminal until reset. The FIFO still accepts pushes but nothing issues.
- `cmd` holds stable from load through ISSUE and BUSY until the next load. It is never changed while the NFC owns it.
- Completion in BUSY and a new issue are separate cycles. After `cpl_valid` the FSM is in IDLE, and `done` is still high, so the next command issues on the following edge.
- `busy` = count≠0 or state∈{ISSUE, BUSY}.

## Timing
- Reset values:
  - `cmd`=0, `h_ready`=1, `h_rej`=0, `cpl_valid`=0, `cpl_cmd`=0, `busy`=0, `to_err`=0.
  - FSM in IDLE, FIFO empty.
- Push-to-issue latency is a minimum of 2 edges: push at edge N, `cmd` loaded at edge N+1 if `done`=1 and IDLE.
- `cpl_valid` asserts the cycle after the edge that sampled `done` rising in BUSY. Width is exactly 1.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by the count, not by pointer equality.
- A simultaneous push and pop with count=DEPTH is impossible by construction. With count=1, a simultaneous push and pop leaves count=1.
- Reset asserted mid-transfer clears everything immediately, including the held `cmd`. The NFC is reset by the same signal.

## Structure
- Shared package `nfc_pkg`:
  - `CMD_W`=33.
  - Field bit positions: RW=32, FA=31:14, MA=13:7, LEN=6:0.
  - `MEM_WORDS`=128.
  - FSM state enum.
  - Legality check as a function.
- One sub-module, `nfc_cmd_fifo`: DEPTH×33 synchronous FIFO with push/pop/count/full/empty and the same `clk`/`rst`.

## Test plan
- Reset, then push one read (flash 00010H, mem 00H, len 64) with `done`=1 → `cmd` equals the pushed value 2 edges after the push. Model drops `done` 1 cycle later and raises it 10 cycles later → single `cpl_valid` with `cpl_cmd` matching, `busy` falls.
- Push 5 commands back-to-back while the model holds `done`=0 (DEPTH=4) → `h_ready` drops after the 4th. The 5th is held and accepted after the first pop. Commands issue in FIFO order.
- Push len=0, then mem 7FH len 2 → both raise `h_rej`, count stays 0, nothing issued. Mem 40H len 64 (sum 128) → accepted.
- Model never lowers `done` after issue → `to_err` set after 16 cycles, FSM halts, later pushes are not issued.
- Assert `rst` during BUSY with 2 queued → all outputs return to reset values, the queue is empty, and no `cpl_valid` occurs.
- Alternating write/read stream of 10 commands against the NFC+flash+RAM models → 10 completions in order, no rejects, no timeout.
